// File: rtl/decode_stage_pkg.sv
// Shared decode definitions for the LittleChip ID stage: opcodes, immediate
// formats, control bundle and the combinational immediate/control decoders.
package rv_decode_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic     reg_we;
        logic     alu_src;
        logic     mem_write;
        logic     mem_read;
        logic     mem_to_reg;
        logic     pc_src;
        logic     uses_rs1;
        logic     uses_rs2;
        imm_fmt_e imm_fmt;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
        ctrl_t c;
        c          = '0;
        c.imm_fmt  = IMM_NONE;
        // Unknown opcodes still count as rs1 readers so the interlock stays conservative
        c.uses_rs1 = 1'b1;
        case (opcode)
            OP: begin
                c.reg_we   = 1'b1;
                c.uses_rs2 = 1'b1;
            end
            OP_IMM: begin
                c.reg_we  = 1'b1;
                c.alu_src = 1'b1;
                c.imm_fmt = IMM_I;
            end
            LOAD: begin
                c.reg_we     = 1'b1;
                c.alu_src    = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.imm_fmt    = IMM_I;
            end
            STORE: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
                c.uses_rs2  = 1'b1;
                c.imm_fmt   = IMM_S;
            end
            BRANCH: begin
                c.pc_src   = 1'b1;
                c.uses_rs2 = 1'b1;
                c.imm_fmt  = IMM_B;
            end
            JAL: begin
                c.reg_we   = 1'b1;
                c.pc_src   = 1'b1;
                c.uses_rs1 = 1'b0;
                c.imm_fmt  = IMM_J;
            end
            JALR: begin
                c.reg_we  = 1'b1;
                c.alu_src = 1'b1;
                c.pc_src  = 1'b1;
                c.imm_fmt = IMM_I;
            end
            LUI, AUIPC: begin
                c.reg_we   = 1'b1;
                c.alu_src  = 1'b1;
                c.uses_rs1 = 1'b0;
                c.imm_fmt  = IMM_U;
            end
            default: c = c;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{i[31]}}, i[31:20]};
            IMM_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   imm = {i[31:12], 12'b0};
            IMM_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/execute/writeback bundle of the decode stage; master is the
// surrounding pipeline, slave is the decode stage itself.
interface decode_stage_if #(
    parameter int INST_WIDTH = 32,
    parameter int DWIDTH     = 32,
    parameter int PC_WIDTH   = 32,
    parameter int NREGS      = 32,
    parameter int CNT_WIDTH  = 32
);
    localparam int AW = $clog2(NREGS);

    logic                  if_valid;
    logic                  if_ready;
    logic [PC_WIDTH-1:0]   if_pc;
    logic [INST_WIDTH-1:0] if_inst;

    logic                  ex_valid;
    logic                  ex_ready;
    logic [PC_WIDTH-1:0]   ex_pc;
    logic [INST_WIDTH-1:0] ex_inst;
    logic [DWIDTH-1:0]     ex_rs1_data;
    logic [DWIDTH-1:0]     ex_rs2_data;
    logic [DWIDTH-1:0]     ex_imm;
    logic [PC_WIDTH-1:0]   ex_branch_target;
    logic [AW-1:0]         ex_rd;
    logic                  ex_reg_we;
    logic                  ex_alu_src;
    logic                  ex_mem_write;
    logic                  ex_mem_read;
    logic                  ex_mem_to_reg;
    logic                  ex_pc_src;

    logic                  wb_we;
    logic [AW-1:0]         wb_addr;
    logic [DWIDTH-1:0]     wb_data;
    logic                  flush;
    logic [CNT_WIDTH-1:0]  stall_cnt;

    modport master (
        output if_valid, if_pc, if_inst, ex_ready, wb_we, wb_addr, wb_data, flush,
        input  if_ready, ex_valid, ex_pc, ex_inst, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_branch_target, ex_rd, ex_reg_we, ex_alu_src, ex_mem_write,
               ex_mem_read, ex_mem_to_reg, ex_pc_src, stall_cnt
    );

    modport slave (
        input  if_valid, if_pc, if_inst, ex_ready, wb_we, wb_addr, wb_data, flush,
        output if_ready, ex_valid, ex_pc, ex_inst, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_branch_target, ex_rd, ex_reg_we, ex_alu_src, ex_mem_write,
               ex_mem_read, ex_mem_to_reg, ex_pc_src, stall_cnt
    );

endinterface

// File: rtl/decode_stage_regfile_bypass.sv
// Architectural register file: two async read ports with write-through from
// the single write port, x0 hardwired to zero, synchronous active-low clear.
module regfile_bypass #(
    parameter int NREGS  = 32,
    parameter int DWIDTH = 32,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AW-1:0]     raddr1,
    input  logic [AW-1:0]     raddr2,
    output logic [DWIDTH-1:0] rdata1,
    output logic [DWIDTH-1:0] rdata2
);

    logic [DWIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = regs[raddr1];
        if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (we && waddr == raddr1) begin
            rdata1 = wdata;
        end
    end

    always_comb begin
        rdata2 = regs[raddr2];
        if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (we && waddr == raddr2) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// LittleChip ID stage: register read with writeback bypass, immediate and
// control decode, ID/EX register with load-use interlock, flush and stall count.
module decode_stage
    import rv_decode_pkg::*;
#(
    parameter int INST_WIDTH = 32,
    parameter int DWIDTH     = 32,
    parameter int PC_WIDTH   = 32,
    parameter int NREGS      = 32,
    parameter int CNT_WIDTH  = 32
) (
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    logic [31:0]       inst32;
    logic [AW-1:0]     rs1;
    logic [AW-1:0]     rs2;
    logic [AW-1:0]     rd;
    ctrl_t             ctrl;
    logic [31:0]       imm32;
    logic [DWIDTH-1:0] rs1_data;
    logic [DWIDTH-1:0] rs2_data;
    logic              hazard;
    logic              if_ready;
    logic              accept;

    logic                  ex_valid;
    logic [PC_WIDTH-1:0]   ex_pc;
    logic [INST_WIDTH-1:0] ex_inst;
    logic [DWIDTH-1:0]     ex_rs1_data;
    logic [DWIDTH-1:0]     ex_rs2_data;
    logic [DWIDTH-1:0]     ex_imm;
    logic [PC_WIDTH-1:0]   ex_branch_target;
    logic [AW-1:0]         ex_rd;
    logic                  ex_reg_we;
    logic                  ex_alu_src;
    logic                  ex_mem_write;
    logic                  ex_mem_read;
    logic                  ex_mem_to_reg;
    logic                  ex_pc_src;
    logic [CNT_WIDTH-1:0]  stall_cnt;
    logic [AW-1:0]         held_rs1;
    logic [AW-1:0]         held_rs2;

    assign inst32 = bus.if_inst[31:0];
    assign rs1    = bus.if_inst[15 +: AW];
    assign rs2    = bus.if_inst[20 +: AW];
    assign rd     = bus.if_inst[7 +: AW];
    assign ctrl   = decode_ctrl(inst32[6:0]);
    assign imm32  = imm_gen(inst32, ctrl.imm_fmt);

    assign held_rs1 = ex_inst[15 +: AW];
    assign held_rs2 = ex_inst[20 +: AW];

    regfile_bypass #(
        .NREGS  (NREGS),
        .DWIDTH (DWIDTH),
        .AW     (AW)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (bus.wb_we),
        .waddr  (bus.wb_addr),
        .wdata  (bus.wb_data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    // The load in ID/EX blocks its consumer even while it is leaving, giving one bubble
    assign hazard = ex_valid && ex_mem_read && (ex_rd != '0) &&
                    ((ctrl.uses_rs1 && rs1 == ex_rd) || (ctrl.uses_rs2 && rs2 == ex_rd));

    assign if_ready = rst && !bus.flush && !hazard && (!ex_valid || bus.ex_ready);
    assign accept   = bus.if_valid && if_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid         <= 1'b0;
            ex_pc            <= '0;
            ex_inst          <= '0;
            ex_rs1_data      <= '0;
            ex_rs2_data      <= '0;
            ex_imm           <= '0;
            ex_branch_target <= '0;
            ex_rd            <= '0;
            ex_reg_we        <= 1'b0;
            ex_alu_src       <= 1'b0;
            ex_mem_write     <= 1'b0;
            ex_mem_read      <= 1'b0;
            ex_mem_to_reg    <= 1'b0;
            ex_pc_src        <= 1'b0;
        end else if (bus.flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid         <= 1'b1;
            ex_pc            <= bus.if_pc;
            ex_inst          <= bus.if_inst;
            ex_rs1_data      <= rs1_data;
            ex_rs2_data      <= rs2_data;
            ex_imm           <= DWIDTH'($signed(imm32));
            ex_branch_target <= bus.if_pc + PC_WIDTH'($signed(imm32));
            ex_rd            <= rd;
            ex_reg_we        <= ctrl.reg_we;
            ex_alu_src       <= ctrl.alu_src;
            ex_mem_write     <= ctrl.mem_write;
            ex_mem_read      <= ctrl.mem_read;
            ex_mem_to_reg    <= ctrl.mem_to_reg;
            ex_pc_src        <= ctrl.pc_src;
        end else if (ex_valid && bus.ex_ready) begin
            ex_valid <= 1'b0;
        end else if (ex_valid) begin
            // Held operands track writebacks so execute never sees a stale value
            if (bus.wb_we && bus.wb_addr != '0 && bus.wb_addr == held_rs1) begin
                ex_rs1_data <= bus.wb_data;
            end
            if (bus.wb_we && bus.wb_addr != '0 && bus.wb_addr == held_rs2) begin
                ex_rs2_data <= bus.wb_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (bus.if_valid && hazard && !bus.flush) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.if_ready         = if_ready;
    assign bus.ex_valid         = ex_valid;
    assign bus.ex_pc            = ex_pc;
    assign bus.ex_inst          = ex_inst;
    assign bus.ex_rs1_data      = ex_rs1_data;
    assign bus.ex_rs2_data      = ex_rs2_data;
    assign bus.ex_imm           = ex_imm;
    assign bus.ex_branch_target = ex_branch_target;
    assign bus.ex_rd            = ex_rd;
    assign bus.ex_reg_we        = ex_reg_we;
    assign bus.ex_alu_src       = ex_alu_src;
    assign bus.ex_mem_write     = ex_mem_write;
    assign bus.ex_mem_read      = ex_mem_read;
    assign bus.ex_mem_to_reg    = ex_mem_to_reg;
    assign bus.ex_pc_src        = ex_pc_src;
    assign bus.stall_cnt        = stall_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: default 32-register build plus
// a 16-register build for the narrowed field decode.
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    decode_stage_if #(.NREGS(32)) bus ();
    decode_stage_if #(.NREGS(16)) bus16 ();

    decode_stage #(.NREGS(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    decode_stage #(.NREGS(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
        bus.wb_we   = 1'b1;
        bus.wb_addr = addr;
        bus.wb_data = data;
        tick();
        bus.wb_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] add_x3_x1_x2;
        add_x3_x1_x2 = enc_r(7'd0, 5'd2, 5'd1, 5'd3);
        rst = 1'b0;
        bus.if_valid = 1'b1;
        bus.if_inst  = add_x3_x1_x2;
        #1;
        n_checks++;
        if (bus.if_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_if_ready: got %0b expected 0", bus.if_ready);
        end
        repeat (3) tick();
        n_checks++;
        if (bus.ex_valid !== 1'b0 || bus.stall_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_state: ex_valid=%0b stall_cnt=%0d expected 0/0", bus.ex_valid, bus.stall_cnt);
        end
        n_checks++;
        if (bus.ex_pc !== 32'd0 || bus.ex_inst !== 32'd0 || bus.ex_imm !== 32'd0 || bus.ex_rs1_data !== 32'd0 ||
            bus.ex_reg_we !== 1'b0 || bus.ex_mem_read !== 1'b0 || bus.ex_branch_target !== 32'd0) begin
            n_fail++; $display("FAIL reset_ex_regs: pc=%0h inst=%0h imm=%0h expected all 0", bus.ex_pc, bus.ex_inst, bus.ex_imm);
        end
        bus.if_valid = 1'b0;
        rst = 1'b1;
        wb_write(5'd1, 32'h1234);
        wb_write(5'd2, 32'h55);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.if_valid = 1'b1;
        bus.if_inst  = add_x3_x1_x2;
        tick();
        bus.if_valid = 1'b0;
        n_checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_rs1_data !== 32'd0 || bus.ex_rs2_data !== 32'd0) begin
            n_fail++; $display("FAIL reset_regfile_clear: valid=%0b rs1=%0h rs2=%0h expected 1/0/0", bus.ex_valid, bus.ex_rs1_data, bus.ex_rs2_data);
        end
        tick();
    endtask

    task automatic test_bypass();
        bus.wb_we    = 1'b1;
        bus.wb_addr  = 5'd5;
        bus.wb_data  = 32'hDEADBEEF;
        bus.if_valid = 1'b1;
        bus.if_pc    = 32'h40;
        bus.if_inst  = enc_r(7'd0, 5'd5, 5'd5, 5'd6);
        tick();
        bus.wb_we    = 1'b0;
        bus.if_valid = 1'b0;
        n_checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_rs1_data !== 32'hDEADBEEF || bus.ex_rs2_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL bypass_operands: valid=%0b rs1=%0h rs2=%0h expected 1/deadbeef/deadbeef", bus.ex_valid, bus.ex_rs1_data, bus.ex_rs2_data);
        end
        n_checks++;
        if (bus.ex_rd !== 5'd6 || bus.ex_pc !== 32'h40 || bus.ex_reg_we !== 1'b1 || bus.ex_alu_src !== 1'b0) begin
            n_fail++; $display("FAIL bypass_ctrl: rd=%0d pc=%0h we=%0b alu_src=%0b expected 6/40/1/0", bus.ex_rd, bus.ex_pc, bus.ex_reg_we, bus.ex_alu_src);
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [31:0] lw_x7, add_dep, add_nodep;
        lw_x7     = enc_i(12'd4, 5'd1, 3'b010, 5'd7, 7'b0000011);
        add_dep   = enc_r(7'd0, 5'd2, 5'd7, 5'd8);
        add_nodep = enc_r(7'd0, 5'd2, 5'd9, 5'd8);
        bus.ex_ready = 1'b1;
        bus.if_valid = 1'b1;
        bus.if_inst  = lw_x7;
        tick();
        n_checks++;
        if (bus.ex_mem_read !== 1'b1 || bus.ex_mem_to_reg !== 1'b1 || bus.ex_imm !== 32'd4 || bus.ex_rd !== 5'd7) begin
            n_fail++; $display("FAIL lw_decode: mem_read=%0b m2r=%0b imm=%0h rd=%0d expected 1/1/4/7", bus.ex_mem_read, bus.ex_mem_to_reg, bus.ex_imm, bus.ex_rd);
        end
        bus.if_inst = add_dep;
        #1;
        n_checks++;
        if (bus.if_ready !== 1'b0) begin
            n_fail++; $display("FAIL hazard_if_ready: got %0b expected 0", bus.if_ready);
        end
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b0 || bus.stall_cnt !== 32'd1) begin
            n_fail++; $display("FAIL hazard_bubble: ex_valid=%0b stall_cnt=%0d expected 0/1", bus.ex_valid, bus.stall_cnt);
        end
        n_checks++;
        if (bus.if_ready !== 1'b1) begin
            n_fail++; $display("FAIL hazard_release: if_ready=%0b expected 1", bus.if_ready);
        end
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_inst !== add_dep || bus.stall_cnt !== 32'd1) begin
            n_fail++; $display("FAIL hazard_dependent: valid=%0b inst=%0h cnt=%0d expected 1/%0h/1", bus.ex_valid, bus.ex_inst, bus.stall_cnt, add_dep);
        end
        bus.if_inst = lw_x7;
        tick();
        bus.if_inst = add_nodep;
        #1;
        n_checks++;
        if (bus.if_ready !== 1'b1) begin
            n_fail++; $display("FAIL nodep_if_ready: got %0b expected 1", bus.if_ready);
        end
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_inst !== add_nodep || bus.stall_cnt !== 32'd1) begin
            n_fail++; $display("FAIL nodep_no_bubble: valid=%0b inst=%0h cnt=%0d expected 1/%0h/1", bus.ex_valid, bus.ex_inst, bus.stall_cnt, add_nodep);
        end
        bus.if_valid = 1'b0;
        tick();
    endtask

    task automatic test_hold_refresh();
        logic [31:0] sub_x3;
        sub_x3 = enc_r(7'b0100000, 5'd5, 5'd4, 5'd3);
        wb_write(5'd4, 32'h4444);
        wb_write(5'd5, 32'h5555);
        bus.ex_ready = 1'b0;
        bus.if_valid = 1'b1;
        bus.if_pc    = 32'h200;
        bus.if_inst  = sub_x3;
        tick();
        bus.if_valid = 1'b0;
        n_checks++;
        if (bus.if_ready !== 1'b0 || bus.ex_rs1_data !== 32'h4444) begin
            n_fail++; $display("FAIL hold_start: if_ready=%0b rs1=%0h expected 0/4444", bus.if_ready, bus.ex_rs1_data);
        end
        tick();
        bus.wb_we   = 1'b1;
        bus.wb_addr = 5'd4;
        bus.wb_data = 32'h11;
        tick();
        bus.wb_we = 1'b0;
        tick();
        n_checks++;
        if (bus.ex_rs1_data !== 32'h11 || bus.ex_rs2_data !== 32'h5555) begin
            n_fail++; $display("FAIL refresh_operands: rs1=%0h rs2=%0h expected 11/5555", bus.ex_rs1_data, bus.ex_rs2_data);
        end
        n_checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_inst !== sub_x3 || bus.ex_pc !== 32'h200 || bus.ex_rd !== 5'd3 ||
            bus.ex_reg_we !== 1'b1 || bus.ex_imm !== 32'd0 || bus.ex_branch_target !== 32'h200) begin
            n_fail++; $display("FAIL hold_unchanged: valid=%0b inst=%0h pc=%0h rd=%0d imm=%0h", bus.ex_valid, bus.ex_inst, bus.ex_pc, bus.ex_rd, bus.ex_imm);
        end
        bus.ex_ready = 1'b1;
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_drain: ex_valid=%0b expected 0", bus.ex_valid);
        end
    endtask

    task automatic test_flush();
        logic [31:0] addi_x10;
        addi_x10 = enc_i(12'd5, 5'd0, 3'b000, 5'd10, 7'b0010011);
        bus.if_valid = 1'b1;
        bus.if_pc    = 32'h300;
        bus.if_inst  = enc_r(7'd0, 5'd5, 5'd5, 5'd6);
        tick();
        bus.if_pc   = 32'h304;
        bus.if_inst = addi_x10;
        bus.flush   = 1'b1;
        bus.wb_we   = 1'b1;
        bus.wb_addr = 5'd12;
        bus.wb_data = 32'h77;
        #1;
        n_checks++;
        if (bus.if_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_if_ready: got %0b expected 0", bus.if_ready);
        end
        tick();
        bus.flush = 1'b0;
        bus.wb_we = 1'b0;
        n_checks++;
        if (bus.ex_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_kill: ex_valid=%0b expected 0", bus.ex_valid);
        end
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_inst !== addi_x10 || bus.ex_pc !== 32'h304 ||
            bus.ex_imm !== 32'd5 || bus.ex_alu_src !== 1'b1) begin
            n_fail++; $display("FAIL flush_reaccept: valid=%0b inst=%0h pc=%0h imm=%0h", bus.ex_valid, bus.ex_inst, bus.ex_pc, bus.ex_imm);
        end
        bus.if_inst = enc_r(7'd0, 5'd0, 5'd12, 5'd13);
        tick();
        n_checks++;
        if (bus.ex_rs1_data !== 32'h77) begin
            n_fail++; $display("FAIL flush_wb_kept: rs1=%0h expected 77", bus.ex_rs1_data);
        end
        bus.if_valid = 1'b0;
        tick();
    endtask

    task automatic test_x0_imm();
        logic [31:0] add_x1_x0;
        add_x1_x0 = enc_r(7'd0, 5'd0, 5'd0, 5'd1);
        bus.wb_we    = 1'b1;
        bus.wb_addr  = 5'd0;
        bus.wb_data  = 32'hFF;
        bus.if_valid = 1'b1;
        bus.if_inst  = add_x1_x0;
        tick();
        bus.wb_we = 1'b0;
        n_checks++;
        if (bus.ex_rs1_data !== 32'd0 || bus.ex_rs2_data !== 32'd0) begin
            n_fail++; $display("FAIL x0_bypass: rs1=%0h rs2=%0h expected 0/0", bus.ex_rs1_data, bus.ex_rs2_data);
        end
        tick();
        n_checks++;
        if (bus.ex_rs1_data !== 32'd0) begin
            n_fail++; $display("FAIL x0_write_dropped: rs1=%0h expected 0", bus.ex_rs1_data);
        end
        bus.if_pc   = 32'h100;
        bus.if_inst = enc_b(13'h1FF8, 5'd2, 5'd1);
        tick();
        n_checks++;
        if (bus.ex_imm !== 32'hFFFFFFF8 || bus.ex_branch_target !== 32'hF8 ||
            bus.ex_pc_src !== 1'b1 || bus.ex_reg_we !== 1'b0) begin
            n_fail++; $display("FAIL beq_imm: imm=%0h target=%0h pc_src=%0b we=%0b expected fffffff8/f8/1/0", bus.ex_imm, bus.ex_branch_target, bus.ex_pc_src, bus.ex_reg_we);
        end
        bus.if_pc   = 32'h104;
        bus.if_inst = enc_s(12'd12, 5'd2, 5'd1);
        tick();
        n_checks++;
        if (bus.ex_imm !== 32'd12 || bus.ex_mem_write !== 1'b1 || bus.ex_alu_src !== 1'b1 || bus.ex_reg_we !== 1'b0) begin
            n_fail++; $display("FAIL sw_decode: imm=%0h mem_write=%0b alu_src=%0b we=%0b expected c/1/1/0", bus.ex_imm, bus.ex_mem_write, bus.ex_alu_src, bus.ex_reg_we);
        end
        bus.if_inst = {20'h12345, 5'd5, 7'b0110111};
        tick();
        n_checks++;
        if (bus.ex_imm !== 32'h12345000 || bus.ex_reg_we !== 1'b1 || bus.ex_rd !== 5'd5) begin
            n_fail++; $display("FAIL lui_decode: imm=%0h we=%0b rd=%0d expected 12345000/1/5", bus.ex_imm, bus.ex_reg_we, bus.ex_rd);
        end
        bus.if_inst = 32'hFFFFFFFF;
        tick();
        n_checks++;
        if (bus.ex_imm !== 32'd0 || bus.ex_reg_we !== 1'b0 || bus.ex_alu_src !== 1'b0 || bus.ex_mem_write !== 1'b0 ||
            bus.ex_mem_read !== 1'b0 || bus.ex_mem_to_reg !== 1'b0 || bus.ex_pc_src !== 1'b0) begin
            n_fail++; $display("FAIL unknown_opcode: imm=%0h we=%0b pc_src=%0b expected all 0", bus.ex_imm, bus.ex_reg_we, bus.ex_pc_src);
        end
        bus.if_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        bus.if_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            bus.if_inst = enc_i(12'(k), 5'd0, 3'b000, 5'd10, 7'b0010011);
            tick();
            n_checks++;
            if (bus.ex_valid !== 1'b1 || bus.ex_imm !== 32'(k)) begin
                n_fail++; $display("FAIL back_to_back_%0d: valid=%0b imm=%0h expected 1/%0h", k, bus.ex_valid, bus.ex_imm, k);
            end
        end
        bus.if_valid = 1'b0;
        tick();
    endtask

    task automatic test_nregs16();
        bus16.wb_we   = 1'b1;
        bus16.wb_addr = 4'd3;
        bus16.wb_data = 32'hABCD;
        tick();
        bus16.wb_we    = 1'b0;
        bus16.if_valid = 1'b1;
        bus16.if_inst  = enc_r(7'd0, 5'd0, 5'd19, 5'd17);
        tick();
        bus16.if_valid = 1'b0;
        n_checks++;
        if (bus16.ex_valid !== 1'b1 || bus16.ex_rs1_data !== 32'hABCD || bus16.ex_rd !== 4'd1) begin
            n_fail++; $display("FAIL nregs16_fields: valid=%0b rs1=%0h rd=%0d expected 1/abcd/1", bus16.ex_valid, bus16.ex_rs1_data, bus16.ex_rd);
        end
        tick();
    endtask

    initial begin
        bus.if_valid = 1'b0; bus.if_pc = '0; bus.if_inst = '0; bus.ex_ready = 1'b1;
        bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0; bus.flush = 1'b0;
        bus16.if_valid = 1'b0; bus16.if_pc = '0; bus16.if_inst = '0; bus16.ex_ready = 1'b1;
        bus16.wb_we = 1'b0; bus16.wb_addr = '0; bus16.wb_data = '0; bus16.flush = 1'b0;
        test_reset();
        test_bypass();
        test_load_use();
        test_hold_refresh();
        test_flush();
        test_x0_imm();
        test_back_to_back();
        test_nregs16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
